counter_sequencer: RTL and testbench

//  Controller that runs one counting job on the WIDTH-bit load-and-add counter.
//  - Accepts a command (step, limit, prescale) over a valid/ready handshake.
//  - Clears the counter, then pulses its ld/v inputs at a programmed rate until count >= limit.
//  - Reports completion, wrap-around overflow and error/abort status.

---
 rtl/counter_sequencer.sv | 157 +++++++++++++++
 tb/tb_counter_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: runs one counting job on an attached load-and-add counter.
// Optional: define COUNTER_SEQ_AUTORELOAD_EN to repeat a finished job.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIVW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [DIVW-1:0]  cmd_div,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_count,
  output logic             cnt_rst,
  output logic             cnt_ld,
  output logic [WIDTH-1:0] cnt_v,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CHECK,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic [DIVW-1:0]  presc_q, presc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  // State and job registers; reset returns straight to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      limit_q <= '0;
      prev_q  <= '0;
      div_q   <= '0;
      presc_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      limit_q <= limit_d;
      prev_q  <= prev_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next-state and strobe logic; abort outranks pause and step checks.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    limit_d   = limit_q;
    prev_d    = prev_q;
    div_d     = div_q;
    presc_d   = presc_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    cnt_rst   = 1'b0;
    cnt_ld    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          step_d  = cmd_step;
          limit_d = cmd_limit;
          div_d   = cmd_div;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_rst = 1'b1;
        prev_d  = '0;
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (step_q == '0 && limit_q != '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_count < prev_q) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_count >= limit_q) begin
          state_d = S_DONE;
        end else begin
          prev_d  = cnt_count;
          presc_d = div_q;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!pause) begin
          if (presc_q != '0) begin
            presc_d = presc_q - DIVW'(1);
          end else begin
            cnt_ld  = 1'b1;
            state_d = S_CHECK;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        if (!ovf_q && !err_q) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign cnt_v = busy ? step_q : '0;
  assign ovf   = ovf_q;
  assign err   = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed jobs checked every cycle against a
// timeline model of the sequencer driving a load-and-add counter.
module tb_counter_sequencer;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [W-1:0] cmd_step = '0;
  logic [W-1:0] cmd_limit = '0;
  logic [D-1:0] cmd_div = '0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cnt_count;
  logic         cmd_ready, cnt_rst, cnt_ld;
  logic [W-1:0] cnt_v;
  logic         busy, done, ovf, err;

  int checks = 0;
  int failures = 0;

  bit           m_ld [0:1023];
  int           m_done;
  bit           m_ovf, m_err;
  logic [W-1:0] m_cnt;
  bit           chk_en = 1'b0;
  int           rel = 0;
  logic [W-1:0] cur_step = '0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(W), .DIVW(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_step(cmd_step), .cmd_limit(cmd_limit), .cmd_div(cmd_div),
    .pause(pause), .abort(abort), .cnt_count(cnt_count),
    .cnt_rst(cnt_rst), .cnt_ld(cnt_ld), .cnt_v(cnt_v),
    .busy(busy), .done(done), .ovf(ovf), .err(err)
  );

  // attached load-and-add counter
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt_count <= '0;
    else if (cnt_rst) cnt_count <= '0;
    else if (cnt_ld) cnt_count <= cnt_count + cnt_v;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s rel=%0d got=%0h want=%0h", nm, rel, act, exp);
    end
  endtask

  // Timeline of a job relative to the accept cycle (rel 0):
  // CLEAR at rel 1, first CHECK at rel 2; each step waits div+1
  // unpaused cycles, loads, then checks on the following cycle.
  task automatic model_job(input logic [W-1:0] st, input logic [W-1:0] lim,
                           input logic [D-1:0] dv, input int ps, input int pl,
                           input int ab);
    int t, need, c, n;
    logic [W-1:0] cnt, prev;
    bit fin;
    for (int i = 0; i < 1024; i++) m_ld[i] = 1'b0;
    m_ovf = 1'b0;
    m_err = 1'b0;
    cnt = '0;
    prev = '0;
    if (st == 0 && lim != 0) begin
      m_err = 1'b1;
      m_done = 2;
    end else begin
      t = 2;
      fin = 1'b0;
      while (!fin) begin
        if (cnt < prev) begin
          m_ovf = 1'b1;
          m_done = t + 1;
          fin = 1'b1;
        end else if (cnt >= lim) begin
          m_done = t + 1;
          fin = 1'b1;
        end else begin
          prev = cnt;
          need = int'(dv) + 1;
          c = t;
          while (need > 0) begin
            c++;
            if (!(c >= ps && c < ps + pl)) need--;
          end
          if (c > 1000) begin
            m_done = 1000;
            fin = 1'b1;
          end else begin
            m_ld[c] = 1'b1;
            cnt = cnt + st;
            t = c + 1;
          end
        end
      end
    end
    if (ab >= 1 && ab < m_done) begin
      m_done = ab + 1;
      m_err = 1'b1;
      m_ovf = 1'b0;
      for (int i = ab; i < 1024; i++) m_ld[i] = 1'b0;
    end
    n = 0;
    for (int i = 0; i < 1024; i++) if (m_ld[i]) n++;
    m_cnt = W'(n * int'(st));
  endtask

  task automatic run_job(input logic [W-1:0] st, input logic [W-1:0] lim,
                         input logic [D-1:0] dv, input int ps, input int pl,
                         input int ab, input bit hold);
    model_job(st, lim, dv, ps, pl, ab);
    @(negedge clk);
    cur_step = st;
    cmd_valid = 1'b1;
    cmd_step = st;
    cmd_limit = lim;
    cmd_div = dv;
    pause = 1'b0;
    abort = 1'b0;
    rel = 0;
    chk_en = 1'b1;
    for (int r = 1; r <= m_done + 2; r++) begin
      @(negedge clk);
      rel = r;
      cmd_valid = hold && (r <= m_done);
      pause = (r >= ps) && (r < ps + pl);
      abort = (r == ab);
    end
    @(negedge clk);
    chk_en = 1'b0;
    cmd_valid = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
  endtask

  // per-cycle comparison against the model timeline
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("cnt_ld", cnt_ld, (rel < 1024) ? m_ld[rel] : 1'b0);
      chk("cnt_rst", cnt_rst, rel == 1);
      chk("busy", busy, rel >= 1 && rel <= m_done);
      chk("cmd_ready", cmd_ready, !(rel >= 1 && rel <= m_done));
      chk("done", done, rel == m_done);
      chk("cnt_v", cnt_v, (rel >= 1 && rel <= m_done) ? cur_step : '0);
      if (rel >= m_done) begin
        chk("ovf", ovf, m_ovf);
        chk("err", err, m_err);
      end
      if (rel == m_done) chk("cnt_count", cnt_count, m_cnt);
    end
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {cnt_rst, cnt_ld, busy, done, ovf, err}, 0);
    chk("rst_cnt_v", cnt_v, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: plain count
    run_job(8'd3, 8'd10, 4'd0, 0, 0, 0, 1'b0);
    chk("t1_done_rel", m_done, 11);
    chk("t1_ld_rels", {m_ld[3], m_ld[5], m_ld[7], m_ld[9]}, 4'hf);
    chk("t1_final", m_cnt, 12);

    // 2: limit zero
    run_job(8'd5, 8'd0, 4'd0, 0, 0, 0, 1'b0);
    chk("t2_done_rel", m_done, 3);
    chk("t2_err", m_err, 0);

    // 3: wrap
    run_job(8'd100, 8'd250, 4'd0, 0, 0, 0, 1'b0);
    chk("t3_done_rel", m_done, 9);
    chk("t3_ovf", m_ovf, 1);
    chk("t3_final", m_cnt, 44);

    // 4: prescaler with pause in the first run window
    run_job(8'd1, 8'd2, 4'd3, 4, 5, 0, 1'b0);
    chk("t4_done_rel", m_done, 18);
    chk("t4_ld_rels", {m_ld[6], m_ld[11], m_ld[16]}, 3'b011);

    // 5: abort in RUN on a would-be load cycle
    run_job(8'd1, 8'd200, 4'd0, 0, 0, 9, 1'b0);
    chk("t5_done_rel", m_done, 10);
    chk("t5_final", m_cnt, 3);

    // abort during pause wins
    run_job(8'd1, 8'd200, 4'd2, 3, 10, 6, 1'b0);
    chk("t5b_done_rel", m_done, 7);

    // abort in DONE is ignored
    run_job(8'd5, 8'd0, 4'd0, 0, 0, 3, 1'b0);
    chk("t5c_err", m_err, 0);

    // 6: zero step, command held throughout
    run_job(8'd0, 8'd5, 4'd0, 0, 0, 0, 1'b1);
    chk("t6_done_rel", m_done, 2);
    chk("t6_err", m_err, 1);

    // reset mid-job
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_step = 8'd1;
    cmd_limit = 8'd200;
    cmd_div = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_outs", {cnt_rst, cnt_ld, busy, done, ovf, err}, 0);
    chk("mid_rst_cnt_v", cnt_v, 0);
    @(negedge clk);
    rst = 1'b1;

    // recovery after reset
    run_job(8'd2, 8'd4, 4'd1, 0, 0, 0, 1'b0);
    chk("rec_done_rel", m_done, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
